vc_arbiter: RTL and testbench
=============================

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk, input, 1: sole clock, all state updates on its rising edge.
- RESET, input, 1: synchronous, active-high reset.
- init, input, 1: arbitration enable; pops are issued only while it is 1.
- VC0_EMPTY, VC1_EMPTY, input, 1 each: virtual-channel FIFO empty flags.
- VC0_VALID, VC1_VALID, input, 1 each: VC FIFO read data is valid this cycle.
- DATA_OUT_VC0, DATA_OUT_VC1, input, 6 each: VC FIFO read data; bit 4 selects the destination (0 = D0, 1 = D1).
- D0_PAUSE, D1_PAUSE, input, 1 each: destination almost-full backpressure.
- D0_FULL, D1_FULL, input, 1 each: destination FIFO full.
- POP_VC0, POP_VC1, output, 1 each: registered pop requests to the VC FIFOs.
- PUSH_D0, PUSH_D1, output, 1 each: push strobes to the destination FIFOs.
- data_to_D0, data_to_D1, output, 6 each: destination write data.
- ARB_STATE, output, 2: current FSM state encoding.
- DROP_ERR, output, 1: sticky flag, set when a word is discarded.
- DROP_CNT, output, 4: saturating count of discarded words.

Function
REQ-002 The FSM SHALL have four states: IDLE=00, GNT0=01, GNT1=10, HOLD=11.
REQ-003 Eligibility SHALL be computed each cycle as:
- e0 = ~VC0_EMPTY.
- e1 = ~VC1_EMPTY.
- go = init & ~D0_PAUSE & ~D1_PAUSE.
REQ-004 State transitions SHALL be:
- Any state with ~init goes to IDLE.
- Any state with init and (D0_PAUSE|D1_PAUSE) goes to HOLD.
- Otherwise, with go true, the next state is GNT0 or GNT1 per the grant rule, or IDLE when e0=e1=0.
REQ-005 POP_VC0 SHALL equal 1 exactly in the cycles the registered state is GNT0, and POP_VC1 exactly in GNT1.
REQ-006 POP_VC0 and POP_VC1 SHALL never be 1 in the same cycle.
REQ-007 Grant rule SHALL be strict priority: GNT0 when e0=1; GNT1 only when e0=0 and e1=1.
REQ-008 Routing SHALL be combinational in the cycle VCx_VALID=1, using bit 4 of DATA_OUT_VCx:
- bit4=0 drives data_to_D0 = DATA_OUT_VCx and PUSH_D0=1.
- bit4=1 drives data_to_D1 = DATA_OUT_VCx and PUSH_D1=1.
REQ-009 When no push is active on a destination, its data_to_Dx SHALL be 6'h00.
REQ-010 Routing latency SHALL be pop in cycle N, VALID in N+1, push in N+1.
REQ-011 If VC0_VALID and VC1_VALID are both 1 and route to the same destination, VC0's word SHALL be pushed and VC1's word dropped.
REQ-012 If they route to different destinations, both words SHALL be pushed in the same cycle.
REQ-013 If a routed word's destination has Dx_FULL=1, PUSH_Dx SHALL stay 0 and the word SHALL be dropped.
REQ-014 Every dropped word SHALL set DROP_ERR and increment DROP_CNT, which saturates at 4'hF.
REQ-015 Two drops in one cycle SHALL add 2 to DROP_CNT, still saturating at 4'hF.
REQ-016 Words already popped before entering HOLD or IDLE SHALL still be routed when their VALID arrives.

Reset
REQ-017 While RESET=1 at a clock edge, the block SHALL set:
- state = IDLE.
- POP_VC0 = POP_VC1 = 0.
- DROP_ERR = 0.
- DROP_CNT = 0.
REQ-018 While RESET=1, PUSH_D0 and PUSH_D1 SHALL be 0 regardless of VALID inputs.
REQ-019 A reset asserted during GNT0 or GNT1 SHALL suppress the pop in the following cycle.
REQ-020 The first pop after reset release SHALL occur no earlier than the second edge after RESET falls.

Configuration
REQ-021 With macro VC_ARB_RR_EN defined, the grant rule SHALL be round-robin:
- A 1-bit last-grant register, reset to 1, is updated on each GNTx entry.
- When e0=e1=1, the channel not granted last is chosen.
- When only one channel is eligible, that channel is chosen.
REQ-022 Without VC_ARB_RR_EN, the strict priority rule of REQ-007 SHALL apply and no last-grant register SHALL exist.

Verification
REQ-023 Scenario 1: init=1, VC0 holds 3 words 6'h05, VC1 empty, no pause -> POP_VC0 high for 3 consecutive cycles; PUSH_D0 high for 3 cycles, each with data_to_D0=6'h05, lagging by 1 cycle.
REQ-024 Scenario 2: both VCs nonempty with 4 words each, macro undefined -> 4 VC0 pops then 4 VC1 pops. With VC_ARB_RR_EN defined -> pops alternate VC0, VC1, VC0, ...
REQ-025 Scenario 3: D1_PAUSE=1 for 5 cycles mid-stream -> ARB_STATE=11 and no pops during the pause; in-flight words are still pushed; popping resumes on the cycle after D1_PAUSE falls.
REQ-026 Scenario 4: VC0 data 6'h12 and VC1 data 6'h33 valid in the same cycle (both bit4=1) -> PUSH_D1=1 with data_to_D1=6'h12; DROP_ERR=1; DROP_CNT=1.
REQ-027 Scenario 5: D0_FULL=1 while 18 words routed to D0 arrive -> PUSH_D0 stays 0; DROP_CNT saturates at 4'hF.
REQ-028 Scenario 6: RESET asserted during GNT1 -> POP_VC1=0 on the next edge; ARB_STATE=00; DROP_CNT=0.

Source files
------------

// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: VC FIFO / destination FIFO signal bundle for the arbiter
interface vc_arbiter_if;
  logic       init;
  logic       VC0_EMPTY, VC1_EMPTY;
  logic       VC0_VALID, VC1_VALID;
  logic [5:0] DATA_OUT_VC0, DATA_OUT_VC1;
  logic       D0_PAUSE, D1_PAUSE;
  logic       D0_FULL, D1_FULL;
  logic       POP_VC0, POP_VC1;
  logic       PUSH_D0, PUSH_D1;
  logic [5:0] data_to_D0, data_to_D1;
  logic [1:0] ARB_STATE;
  logic       DROP_ERR;
  logic [3:0] DROP_CNT;
  modport slave (
    input  init, VC0_EMPTY, VC1_EMPTY, VC0_VALID, VC1_VALID, DATA_OUT_VC0, DATA_OUT_VC1,
           D0_PAUSE, D1_PAUSE, D0_FULL, D1_FULL,
    output POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, data_to_D0, data_to_D1, ARB_STATE, DROP_ERR, DROP_CNT
  );
  modport master (
    output init, VC0_EMPTY, VC1_EMPTY, VC0_VALID, VC1_VALID, DATA_OUT_VC0, DATA_OUT_VC1,
           D0_PAUSE, D1_PAUSE, D0_FULL, D1_FULL,
    input  POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, data_to_D0, data_to_D1, ARB_STATE, DROP_ERR, DROP_CNT
  );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: two-VC to two-destination arbiter/router; VC_ARB_RR_EN selects round-robin grants
module vc_arbiter (
  input logic        clk,
  input logic        RESET,
  vc_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10, HOLD = 2'b11} state_t;
  state_t     state, state_nx, pick;
  logic       e0, e1, v0, v1, w00, w10, w01, w11;
  logic [1:0] drops;
  logic [4:0] sum;
  logic [3:0] cnt;
  logic       err;
`ifdef VC_ARB_RR_EN
  logic       last;
  // grant choice: alternate when both channels are eligible
  always_comb pick = (e0 & e1) ? (last ? GNT0 : GNT1) : e0 ? GNT0 : e1 ? GNT1 : IDLE;
  // remember which channel was granted most recently (1 = VC1)
  always_ff @(posedge clk)
    if (RESET) last <= 1'b1;
    else if (state_nx == GNT0) last <= 1'b0;
    else if (state_nx == GNT1) last <= 1'b1;
`else
  // grant choice: VC0 always wins when eligible
  always_comb pick = e0 ? GNT0 : e1 ? GNT1 : IDLE;
`endif
  // next state: disable beats backpressure, backpressure beats grants
  always_comb begin
    e0 = ~bus.VC0_EMPTY;
    e1 = ~bus.VC1_EMPTY;
    state_nx = ~bus.init ? IDLE : (bus.D0_PAUSE | bus.D1_PAUSE) ? HOLD : pick;
  end
  // state register
  always_ff @(posedge clk)
    if (RESET) state <= IDLE;
    else state <= state_nx;
  // pops decode the registered state; routing is combinational on VALID
  always_comb begin
    bus.ARB_STATE = state;
    bus.POP_VC0 = state == GNT0;
    bus.POP_VC1 = state == GNT1;
    v0 = bus.VC0_VALID & ~RESET;
    v1 = bus.VC1_VALID & ~RESET;
    w00 = v0 & ~bus.DATA_OUT_VC0[4];
    w01 = v0 & bus.DATA_OUT_VC0[4];
    w10 = v1 & ~bus.DATA_OUT_VC1[4];
    w11 = v1 & bus.DATA_OUT_VC1[4];
    bus.PUSH_D0 = (w00 | w10) & ~bus.D0_FULL;
    bus.PUSH_D1 = (w01 | w11) & ~bus.D1_FULL;
    bus.data_to_D0 = ~bus.PUSH_D0 ? 6'h00 : w00 ? bus.DATA_OUT_VC0 : bus.DATA_OUT_VC1;
    bus.data_to_D1 = ~bus.PUSH_D1 ? 6'h00 : w01 ? bus.DATA_OUT_VC0 : bus.DATA_OUT_VC1;
    drops = {1'b0, v0} + {1'b0, v1} - {1'b0, bus.PUSH_D0} - {1'b0, bus.PUSH_D1};
    sum = {1'b0, cnt} + {3'b000, drops};
    bus.DROP_CNT = cnt;
    bus.DROP_ERR = err;
  end
  // every valid word not accepted by a push is a drop; count saturates
  always_ff @(posedge clk)
    if (RESET) begin
      cnt <= 4'h0;
      err <= 1'b0;
    end else begin
      cnt <= sum[4] ? 4'hF : sum[3:0];
      err <= err | (|drops);
    end
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: scenario and randomized model-based checks of vc_arbiter
module tb_vc_arbiter;
  logic clk = 0, RESET = 1;
  always #5 clk = ~clk;
  vc_arbiter_if bus();
  vc_arbiter dut (.clk(clk), .RESET(RESET), .bus(bus));
  logic init, p0, p1, f0, f1, fm, flush = 0;
  logic d_e0, d_e1, d_v0, d_v1;
  logic [5:0] d_d0, d_d1;
  logic [5:0] m0 [0:63];
  logic [5:0] m1 [0:63];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, n0, n1;
  logic fv0 = 0, fv1 = 0;
  logic [5:0] fd0 = 0, fd1 = 0;
  int pass = 0, total = 0, cyc = 0;
  int pc0[$], pc1[$], pall[$], pseq[$], uc0[$], uc1[$];
  logic [5:0] ud0[$], ud1[$];
  assign n0 = wp0 - rp0;
  assign n1 = wp1 - rp1;
  assign bus.init = init;
  assign bus.D0_PAUSE = p0;
  assign bus.D1_PAUSE = p1;
  assign bus.D0_FULL = f0;
  assign bus.D1_FULL = f1;
  assign bus.VC0_EMPTY = fm ? (n0 == 0 || (n0 == 1 && bus.POP_VC0)) : d_e0;
  assign bus.VC1_EMPTY = fm ? (n1 == 0 || (n1 == 1 && bus.POP_VC1)) : d_e1;
  assign bus.VC0_VALID = fm ? fv0 : d_v0;
  assign bus.VC1_VALID = fm ? fv1 : d_v1;
  assign bus.DATA_OUT_VC0 = fm ? fd0 : d_d0;
  assign bus.DATA_OUT_VC1 = fm ? fd1 : d_d1;
  always @(posedge clk) begin
    if (flush) begin
      rp0 <= wp0; rp1 <= wp1; fv0 <= 0; fv1 <= 0;
    end else begin
      fv0 <= bus.POP_VC0 && n0 > 0;
      fv1 <= bus.POP_VC1 && n1 > 0;
      if (bus.POP_VC0 && n0 > 0) begin fd0 <= m0[rp0[5:0]]; rp0 <= rp0 + 1; end
      if (bus.POP_VC1 && n1 > 0) begin fd1 <= m1[rp1[5:0]]; rp1 <= rp1 + 1; end
    end
  end
  always @(negedge clk) begin
    if (bus.POP_VC0) begin pc0.push_back(cyc); pall.push_back(cyc); pseq.push_back(0); end
    if (bus.POP_VC1) begin pc1.push_back(cyc); pall.push_back(cyc); pseq.push_back(1); end
    if (bus.PUSH_D0) begin uc0.push_back(cyc); ud0.push_back(bus.data_to_D0); end
    if (bus.PUSH_D1) begin uc1.push_back(cyc); ud1.push_back(bus.data_to_D1); end
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", pass, total);
    $fatal(1);
  end

  task step;
    @(posedge clk); #1;
  endtask
  task idle;
    init = 0; p0 = 0; p1 = 0; f0 = 0; f1 = 0; fm = 0;
    d_e0 = 1; d_e1 = 1; d_v0 = 0; d_v1 = 0; d_d0 = 0; d_d1 = 0;
  endtask
  task clrlog;
    pc0.delete(); pc1.delete(); pall.delete(); pseq.delete();
    uc0.delete(); uc1.delete(); ud0.delete(); ud1.delete();
  endtask
  task do_reset;
    step; RESET = 1; flush = 1; idle;
    step; step; RESET = 0; flush = 0;
  endtask
  task load(input int ch, input logic [5:0] w);
    if (ch == 0) begin m0[wp0[5:0]] = w; wp0++; end
    else begin m1[wp1[5:0]] = w; wp1++; end
  endtask

  task test_reset;
    idle; step; RESET = 1; init = 1; d_e0 = 0; d_v0 = 1; d_d0 = 6'h05; d_v1 = 1; d_d1 = 6'h33;
    step; step; @(negedge clk);
    total++; if (bus.ARB_STATE !== 2'b00) $display("FAIL rst_state: got %0h want 0", bus.ARB_STATE); else pass++;
    total++; if (bus.POP_VC0 !== 0 || bus.POP_VC1 !== 0) $display("FAIL rst_pop: got %b%b want 00", bus.POP_VC0, bus.POP_VC1); else pass++;
    total++; if (bus.PUSH_D0 !== 0 || bus.PUSH_D1 !== 0) $display("FAIL rst_push: got %b%b want 00", bus.PUSH_D0, bus.PUSH_D1); else pass++;
    total++; if (bus.data_to_D0 !== 6'h00 || bus.data_to_D1 !== 6'h00) $display("FAIL rst_data: got %0h %0h want 0 0", bus.data_to_D0, bus.data_to_D1); else pass++;
    total++; if (bus.DROP_CNT !== 4'h0 || bus.DROP_ERR !== 0) $display("FAIL rst_drop: got %0h %b want 0 0", bus.DROP_CNT, bus.DROP_ERR); else pass++;
    step; RESET = 0; d_v0 = 0; d_v1 = 0;
    @(negedge clk);
    total++; if (bus.POP_VC0 !== 0) $display("FAIL rst_release_pop: got %b want 0", bus.POP_VC0); else pass++;
    step; @(negedge clk);
    total++; if (bus.POP_VC0 !== 1) $display("FAIL rst_first_pop: got %b want 1", bus.POP_VC0); else pass++;
    idle;
  endtask

  task test_single;
    do_reset; fm = 1;
    for (int i = 0; i < 3; i++) load(0, 6'h05);
    clrlog; init = 1;
    repeat (8) step;
    init = 0;
    total++; if (pc0.size() !== 3 || pc1.size() !== 0) $display("FAIL s1_pops: got %0d/%0d want 3/0", pc0.size(), pc1.size()); else pass++;
    total++; if (pc0[2] - pc0[0] !== 2) $display("FAIL s1_consec: got span %0d want 2", pc0[2] - pc0[0]); else pass++;
    total++; if (uc0.size() !== 3 || uc1.size() !== 0) $display("FAIL s1_pushes: got %0d/%0d want 3/0", uc0.size(), uc1.size()); else pass++;
    total++; if (uc0[0] !== pc0[0] + 1 || uc0[2] !== pc0[2] + 1) $display("FAIL s1_lag: got %0d,%0d want %0d,%0d", uc0[0], uc0[2], pc0[0] + 1, pc0[2] + 1); else pass++;
    for (int i = 0; i < 3; i++) begin
      total++; if (ud0[i] !== 6'h05) $display("FAIL s1_data%0d: got %0h want 05", i, ud0[i]); else pass++;
    end
  endtask

  task test_order;
    int eseq[$];
    int a, b;
    logic lst;
    do_reset; fm = 1;
    for (int i = 0; i < 4; i++) begin load(0, 6'(i + 1)); load(1, 6'(6'h11 + i)); end
    a = 4; b = 4; lst = 1;
    while (a + b > 0) begin
      int c;
`ifdef VC_ARB_RR_EN
      c = (a > 0 && b > 0) ? (lst ? 0 : 1) : (a > 0 ? 0 : 1);
`else
      c = a > 0 ? 0 : 1;
`endif
      if (c == 0) a--; else b--;
      lst = c[0];
      eseq.push_back(c);
    end
    clrlog; init = 1;
    repeat (14) step;
    init = 0;
    total++; if (pseq.size() !== 8) $display("FAIL s2_count: got %0d want 8", pseq.size()); else pass++;
    for (int i = 0; i < 8; i++) begin
      total++; if (pseq[i] !== eseq[i]) $display("FAIL s2_order%0d: got VC%0d want VC%0d", i, pseq[i], eseq[i]); else pass++;
    end
    total++; if (pall[7] - pall[0] !== 7) $display("FAIL s2_consec: got span %0d want 7", pall[7] - pall[0]); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++; if (ud0[i] !== 6'(i + 1) || ud1[i] !== 6'(6'h11 + i)) $display("FAIL s2_data%0d: got %0h %0h want %0h %0h", i, ud0[i], ud1[i], i + 1, 6'h11 + i); else pass++;
    end
  endtask

  task test_pause;
    do_reset; fm = 1;
    for (int i = 0; i < 10; i++) load(0, 6'h05);
    clrlog; init = 1;
    repeat (3) step;
    p1 = 1;
    for (int i = 0; i < 4; i++) begin
      step; @(negedge clk);
      total++; if (bus.ARB_STATE !== 2'b11 || bus.POP_VC0 !== 0) $display("FAIL s3_hold%0d: got state %0h pop %b want 3 0", i, bus.ARB_STATE, bus.POP_VC0); else pass++;
      if (i == 0) begin
        total++; if (bus.PUSH_D0 !== 1 || bus.data_to_D0 !== 6'h05) $display("FAIL s3_inflight: got %b %0h want 1 05", bus.PUSH_D0, bus.data_to_D0); else pass++;
      end
    end
    step; p1 = 0; @(negedge clk);
    total++; if (bus.ARB_STATE !== 2'b11 || bus.POP_VC0 !== 0) $display("FAIL s3_hold_last: got state %0h pop %b want 3 0", bus.ARB_STATE, bus.POP_VC0); else pass++;
    step; @(negedge clk);
    total++; if (bus.ARB_STATE !== 2'b01 || bus.POP_VC0 !== 1) $display("FAIL s3_resume: got state %0h pop %b want 1 1", bus.ARB_STATE, bus.POP_VC0); else pass++;
    repeat (15) step;
    init = 0; step;
    total++; if (uc0.size() !== 10) $display("FAIL s3_total: got %0d pushes want 10", uc0.size()); else pass++;
  endtask

  task test_collision;
    do_reset;
    step; d_v0 = 1; d_d0 = 6'h12; d_v1 = 1; d_d1 = 6'h33; @(negedge clk);
    total++; if (bus.PUSH_D1 !== 1 || bus.data_to_D1 !== 6'h12) $display("FAIL s4_push: got %b %0h want 1 12", bus.PUSH_D1, bus.data_to_D1); else pass++;
    total++; if (bus.PUSH_D0 !== 0 || bus.data_to_D0 !== 6'h00) $display("FAIL s4_d0_idle: got %b %0h want 0 00", bus.PUSH_D0, bus.data_to_D0); else pass++;
    step; d_d0 = 6'h05; @(negedge clk);
    total++; if (bus.DROP_ERR !== 1 || bus.DROP_CNT !== 4'h1) $display("FAIL s4_drop: got %b %0h want 1 1", bus.DROP_ERR, bus.DROP_CNT); else pass++;
    total++; if (bus.PUSH_D0 !== 1 || bus.data_to_D0 !== 6'h05 || bus.PUSH_D1 !== 1 || bus.data_to_D1 !== 6'h33) $display("FAIL split_push: got %b %0h %b %0h want 1 05 1 33", bus.PUSH_D0, bus.data_to_D0, bus.PUSH_D1, bus.data_to_D1); else pass++;
    step; d_v0 = 0; d_v1 = 0; @(negedge clk);
    total++; if (bus.DROP_CNT !== 4'h1 || bus.PUSH_D1 !== 0 || bus.data_to_D1 !== 6'h00) $display("FAIL split_nodrop: got %0h %b %0h want 1 0 00", bus.DROP_CNT, bus.PUSH_D1, bus.data_to_D1); else pass++;
    step; f0 = 1; d_v0 = 1; d_d0 = 6'h01; d_v1 = 1; d_d1 = 6'h02; @(negedge clk);
    total++; if (bus.PUSH_D0 !== 0) $display("FAIL dbl_push: got %b want 0", bus.PUSH_D0); else pass++;
    step; f0 = 0; d_v0 = 0; d_v1 = 0; @(negedge clk);
    total++; if (bus.DROP_CNT !== 4'h3) $display("FAIL dbl_cnt: got %0h want 3", bus.DROP_CNT); else pass++;
  endtask

  task test_full;
    do_reset; f0 = 1;
    for (int i = 0; i < 18; i++) begin
      step; d_v0 = 1; d_d0 = 6'($urandom) & 6'h2F; @(negedge clk);
      total++; if (bus.PUSH_D0 !== 0 || bus.DROP_CNT !== 4'(i > 15 ? 15 : i)) $display("FAIL s5_word%0d: got push %b cnt %0h want 0 %0h", i, bus.PUSH_D0, bus.DROP_CNT, i > 15 ? 15 : i); else pass++;
    end
    step; d_v0 = 0; @(negedge clk);
    total++; if (bus.DROP_CNT !== 4'hF || bus.DROP_ERR !== 1) $display("FAIL s5_sat: got %0h %b want F 1", bus.DROP_CNT, bus.DROP_ERR); else pass++;
    idle;
  endtask

  task test_reset_mid;
    bit found;
    idle; fm = 1;
    for (int i = 0; i < 6; i++) load(1, 6'h2A);
    init = 1; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step; @(negedge clk);
      found = bus.ARB_STATE == 2'b10;
    end
    total++; if (!found) $display("FAIL s6_gnt1: got no GNT1 within 10 cycles want GNT1"); else pass++;
    @(posedge clk); #1; RESET = 1;
    step; @(negedge clk);
    total++; if (bus.POP_VC1 !== 0 || bus.ARB_STATE !== 2'b00) $display("FAIL s6_pop: got %b %0h want 0 0", bus.POP_VC1, bus.ARB_STATE); else pass++;
    total++; if (bus.DROP_CNT !== 4'h0 || bus.DROP_ERR !== 0) $display("FAIL s6_cnt: got %0h %b want 0 0", bus.DROP_CNT, bus.DROP_ERR); else pass++;
    step; flush = 1; idle;
    step; RESET = 0; flush = 0;
  endtask

  task test_random;
    int es, ec, pushes;
    bit ee, lst, hp[2];
    logic [5:0] hd[2];
    do_reset;
    es = 0; ec = 0; ee = 0; lst = 1;
    for (int n = 0; n < 300; n++) begin
      step;
      init = $urandom_range(0, 7) != 0;
      p0 = $urandom_range(0, 7) == 0; p1 = $urandom_range(0, 7) == 0;
      d_e0 = 1'($urandom); d_e1 = 1'($urandom);
      d_v0 = 1'($urandom); d_v1 = 1'($urandom);
      d_d0 = 6'($urandom); d_d1 = 6'($urandom);
      f0 = $urandom_range(0, 3) == 0; f1 = $urandom_range(0, 3) == 0;
      @(negedge clk);
      pushes = 0;
      for (int k = 0; k < 2; k++) begin
        bit has, full;
        logic [5:0] w;
        has = 1; w = 0;
        if (d_v0 && d_d0[4] == k[0]) w = d_d0;
        else if (d_v1 && d_d1[4] == k[0]) w = d_d1;
        else has = 0;
        full = k == 0 ? f0 : f1;
        hp[k] = has && !full;
        hd[k] = hp[k] ? w : 6'h00;
        pushes += int'(hp[k]);
      end
      total++; if (bus.PUSH_D0 !== hp[0] || bus.data_to_D0 !== hd[0]) $display("FAIL rnd%0d_d0: got %b %0h want %b %0h", n, bus.PUSH_D0, bus.data_to_D0, hp[0], hd[0]); else pass++;
      total++; if (bus.PUSH_D1 !== hp[1] || bus.data_to_D1 !== hd[1]) $display("FAIL rnd%0d_d1: got %b %0h want %b %0h", n, bus.PUSH_D1, bus.data_to_D1, hp[1], hd[1]); else pass++;
      total++; if (bus.ARB_STATE !== 2'(es)) $display("FAIL rnd%0d_state: got %0h want %0h", n, bus.ARB_STATE, es); else pass++;
      total++; if (bus.POP_VC0 !== (es == 1) || bus.POP_VC1 !== (es == 2)) $display("FAIL rnd%0d_pop: got %b%b want %b%b", n, bus.POP_VC0, bus.POP_VC1, es == 1, es == 2); else pass++;
      total++; if (bus.DROP_CNT !== 4'(ec) || bus.DROP_ERR !== ee) $display("FAIL rnd%0d_drop: got %0h %b want %0h %b", n, bus.DROP_CNT, bus.DROP_ERR, ec, ee); else pass++;
      ec += int'(d_v0) + int'(d_v1) - pushes;
      ee = ee || (int'(d_v0) + int'(d_v1) > pushes);
      if (ec > 15) ec = 15;
      if (!init) es = 0;
      else if (p0 || p1) es = 3;
      else begin
`ifdef VC_ARB_RR_EN
        es = (!d_e0 && !d_e1) ? (lst ? 1 : 2) : !d_e0 ? 1 : !d_e1 ? 2 : 0;
`else
        es = !d_e0 ? 1 : !d_e1 ? 2 : 0;
`endif
        if (es == 1) lst = 0;
        if (es == 2) lst = 1;
      end
    end
    idle;
  endtask

  initial begin
    idle;
    test_reset;
    test_single;
    test_order;
    test_pause;
    test_collision;
    test_full;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
